// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit buffer with out-of-order writeback and operand lookup
module reorder_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_DEPTH  = 8,
    parameter int REG_W      = 5,
    localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid_i,
    input  logic [REG_W-1:0]      alloc_rd_i,
    input  logic                  alloc_is_store_i,
    output logic                  alloc_ready_o,
    output logic [TAG_W-1:0]      alloc_tag_o,
    input  logic                  wb_valid_i,
    input  logic [TAG_W-1:0]      wb_tag_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic                  commit_valid_o,
    output logic [REG_W-1:0]      commit_rd_o,
    output logic [DATA_WIDTH-1:0] commit_data_o,
    output logic                  commit_is_store_o,
    input  logic                  commit_ready_i,
    input  logic [TAG_W-1:0]      lookup_tag_i,
    output logic                  lookup_done_o,
    output logic [DATA_WIDTH-1:0] lookup_data_o,
    input  logic                  flush_i,
    output logic [TAG_W:0]        count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic                  r_valid    [ROB_DEPTH];
    logic                  r_done     [ROB_DEPTH];
    logic [REG_W-1:0]      r_rd       [ROB_DEPTH];
    logic                  r_is_store [ROB_DEPTH];
    logic [DATA_WIDTH-1:0] r_data     [ROB_DEPTH];
    logic [TAG_W-1:0]      r_head;
    logic [TAG_W-1:0]      r_tail;
    logic [TAG_W:0]        r_count;

    logic w_full;
    logic w_alloc;
    logic w_commit;
    logic w_lookup_done;

    assign w_full        = (r_count == (TAG_W+1)'(ROB_DEPTH));
    assign full_o        = w_full;
    assign empty_o       = (r_count == '0);
    assign count_o       = r_count;
    assign alloc_ready_o = !w_full;
    assign alloc_tag_o   = r_tail;

    // Head outputs come from registered state only; a writeback lands one cycle later.
    assign commit_valid_o    = r_valid[r_head] && r_done[r_head];
    assign commit_rd_o       = r_rd[r_head];
    assign commit_data_o     = r_data[r_head];
    assign commit_is_store_o = r_is_store[r_head];

    assign w_lookup_done = r_valid[lookup_tag_i] && r_done[lookup_tag_i];
    assign lookup_done_o = w_lookup_done;
    assign lookup_data_o = w_lookup_done ? r_data[lookup_tag_i] : '0;

    assign w_alloc  = alloc_valid_i && !w_full;
    assign w_commit = commit_valid_o && commit_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_valid[i]    <= 1'b0;
                r_done[i]     <= 1'b0;
                r_rd[i]       <= '0;
                r_is_store[i] <= 1'b0;
                r_data[i]     <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (wb_valid_i && r_valid[wb_tag_i]) begin
                r_done[wb_tag_i] <= 1'b1;
                r_data[wb_tag_i] <= wb_data_i;
            end
            // Tail is never the committing head here: that needs full, which blocks allocation.
            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_alloc) begin
                r_valid[r_tail]    <= 1'b1;
                r_done[r_tail]     <= 1'b0;
                r_rd[r_tail]       <= alloc_rd_i;
                r_is_store[r_tail] <= alloc_is_store_i;
                r_tail             <= r_tail + 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
